// File: rtl/sequential_multiplier_unit.sv
// Iterative RV32M/RV64M multiplier: shift-add over BITS_PER_CYCLE multiplier bits per clock.
// Define APX_ACC_CONTROL_EN to build the accuracy_level operand-truncation / digit-skip path.
module sequential_multiplier_unit #(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 2
) (
   input  logic            CLK,
   input  logic            reset_n,
   input  logic            mul_valid_in,
   input  logic [6:0]      opcode,
   input  logic [6:0]      funct7,
   input  logic [2:0]      funct3,
   input  logic [7:0]      accuracy_level,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            mul_unit_busy,
   output logic            mul_valid_out,
   output logic [XLEN-1:0] mul_output
);

   localparam int N  = XLEN / BITS_PER_CYCLE;
   localparam int CW = $clog2(N + 1);
   localparam int PW = 2 * XLEN;

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   acc_q, mcand_q, partial, acc_next;
   logic [XLEN-1:0] mplier_q, out_q;
   logic [CW-1:0]   cnt_q;
   logic            neg_q, hi_q;

   logic            req_ok, accept;
   logic            rs1_neg, rs2_neg;
   logic [XLEN-1:0] mag1, mag2;
   logic [PW-1:0]   load_mcand;
   logic [XLEN-1:0] load_mplier;
   logic [CW-1:0]   load_cnt;

   function automatic logic [XLEN-1:0] negate_op(input logic [XLEN-1:0] v);
      return (~v) + XLEN'(1);
   endfunction

   function automatic logic [XLEN-1:0] finalize(input logic [PW-1:0] p, input logic neg,
                                                input logic hi);
      logic [PW-1:0] s;
      s = neg ? ((~p) + PW'(1)) : p;
      return hi ? s[PW-1:XLEN] : s[XLEN-1:0];
   endfunction

   assign req_ok = mul_valid_in && (opcode == 7'b0110011) && (funct7 == 7'b0000001) && !funct3[2];
   assign accept = req_ok && (state_q != CALC);

   // MUL low half is sign-agnostic, so it runs unsigned; MULHSU treats only rs1 as signed.
   always_comb begin
      rs1_neg = ((funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10)) && rs1[XLEN-1];
      rs2_neg = (funct3[1:0] == 2'b01) && rs2[XLEN-1];
      mag1    = rs1_neg ? negate_op(rs1) : rs1;
      mag2    = rs2_neg ? negate_op(rs2) : rs2;
   end

`ifdef APX_ACC_CONTROL_EN
   logic [7:0]      k_lvl, skip_dig;
   logic [XLEN-1:0] keep_mask;

   // Skipped leading digits are all zero after truncation, so pre-shifting keeps the sum exact.
   always_comb begin
      k_lvl       = (accuracy_level > 8'(XLEN / 2)) ? 8'(XLEN / 2) : accuracy_level;
      keep_mask   = {XLEN{1'b1}} << k_lvl;
      skip_dig    = k_lvl / 8'(BITS_PER_CYCLE);
      load_mcand  = {{XLEN{1'b0}}, mag1 & keep_mask} << (skip_dig * 8'(BITS_PER_CYCLE));
      load_mplier = (mag2 & keep_mask) >> (skip_dig * 8'(BITS_PER_CYCLE));
      load_cnt    = CW'(N) - CW'(skip_dig);
   end
`else
   logic unused_acc;
   assign unused_acc = ^accuracy_level;

   always_comb begin
      load_mcand  = {{XLEN{1'b0}}, mag1};
      load_mplier = mag2;
      load_cnt    = CW'(N);
   end
`endif

   always_comb begin
      partial = '0;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         if (mplier_q[i]) partial = partial + (mcand_q << i);
      end
      acc_next = acc_q + partial;
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = CALC;
         CALC:    if (cnt_q == CW'(1)) state_d = DONE;
         DONE:    state_d = accept ? CALC : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mul_unit_busy = (state_q == CALC);
      mul_valid_out = (state_q == DONE);
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         hi_q     <= 1'b0;
         out_q    <= '0;
      end else if (accept) begin
         acc_q    <= '0;
         mcand_q  <= load_mcand;
         mplier_q <= load_mplier;
         cnt_q    <= load_cnt;
         neg_q    <= rs1_neg ^ rs2_neg;
         hi_q     <= (funct3[1:0] != 2'b00);
      end else if (state_q == CALC) begin
         acc_q    <= acc_next;
         mcand_q  <= mcand_q << BITS_PER_CYCLE;
         mplier_q <= mplier_q >> BITS_PER_CYCLE;
         cnt_q    <= cnt_q - CW'(1);
         if (cnt_q == CW'(1)) out_q <= finalize(acc_next, neg_q, hi_q);
      end
   end

   assign mul_output = out_q;

endmodule

// File: tb/tb_sequential_multiplier_unit.sv
// Self-checking bench for sequential_multiplier_unit (XLEN=32, BITS_PER_CYCLE=2):
// arithmetic reference model plus hand-computed pinned results at fixed cycles.
module tb_sequential_multiplier_unit;

   localparam int XLEN = 32;
   localparam int BPC  = 2;
   localparam int N    = XLEN / BPC;
`ifdef APX_ACC_CONTROL_EN
   localparam bit APX = 1'b1;
`else
   localparam bit APX = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        reset_n = 1'b0;
   logic        mul_valid_in = 1'b0;
   logic [6:0]  opcode = 7'd0;
   logic [6:0]  funct7 = 7'd0;
   logic [2:0]  funct3 = 3'd0;
   logic [7:0]  accuracy_level = 8'd0;
   logic [31:0] rs1 = 32'd0;
   logic [31:0] rs2 = 32'd0;
   logic        mul_unit_busy, mul_valid_out;
   logic [31:0] mul_output;

   always #5 CLK = ~CLK;

   sequential_multiplier_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(BPC)) dut (
      .CLK(CLK), .reset_n(reset_n), .mul_valid_in(mul_valid_in), .opcode(opcode),
      .funct7(funct7), .funct3(funct3), .accuracy_level(accuracy_level), .rs1(rs1), .rs2(rs2),
      .mul_unit_busy(mul_unit_busy), .mul_valid_out(mul_valid_out), .mul_output(mul_output)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit done = 1'b0;

   int          pin_cyc[256];
   int          pin_kind[256];
   logic [31:0] pin_val[256];
   int          pin_wr = 0;

   // ---------------- reference model ----------------
   function automatic logic [31:0] model_res(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b, input logic [7:0] acc);
      int k;
      longint unsigned ma, mb, p;
      bit sa, sb;
      k  = APX ? ((acc > 8'd16) ? 16 : int'(acc)) : 0;
      sa = ((f3[1:0] == 2'd1) || (f3[1:0] == 2'd2)) && a[31];
      sb = (f3[1:0] == 2'd1) && b[31];
      ma = sa ? (64'd4294967296 - {32'd0, a}) : {32'd0, a};
      mb = sb ? (64'd4294967296 - {32'd0, b}) : {32'd0, b};
      ma = (ma >> k) << k;
      mb = (mb >> k) << k;
      p  = ma * mb;
      if (sa ^ sb) p = -p;
      return (f3[1:0] == 2'd0) ? p[31:0] : p[63:32];
   endfunction

   function automatic int model_lat(input logic [7:0] acc);
      int k;
      k = APX ? ((acc > 8'd16) ? 16 : int'(acc)) : 0;
      return N - k / BPC;
   endfunction

   logic req_ok;
   assign req_ok = mul_valid_in && (opcode == 7'b0110011) && (funct7 == 7'b0000001) && !funct3[2];

   int          rem = 0;
   logic [31:0] pend = 32'd0;
   logic [31:0] exp_out = 32'd0;
   logic        exp_valid = 1'b0;

   always @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         rem <= 0;
         pend <= 32'd0;
         exp_out <= 32'd0;
         exp_valid <= 1'b0;
      end else begin
         exp_valid <= (rem == 1);
         if (rem == 1) exp_out <= pend;
         if (rem > 0) rem <= rem - 1;
         else if (req_ok) begin
            rem  <= model_lat(accuracy_level);
            pend <= model_res(funct3, rs1, rs2, accuracy_level);
         end
      end
   end

   // ---------------- compare process ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
      end
   endtask

   initial begin : compare
      int pin_rd;
      pin_rd = 0;
      forever begin
         @(negedge CLK);
         cyc++;
         chk("busy", 64'(mul_unit_busy), 64'(rem != 0));
         chk("valid_out", 64'(mul_valid_out), 64'(exp_valid));
         chk("mul_output", 64'(mul_output), 64'(exp_out));
         while (pin_rd < pin_wr && pin_cyc[pin_rd] <= cyc) begin
            if (pin_cyc[pin_rd] < cyc) chk("pin_skipped", 64'(pin_cyc[pin_rd]), 64'(cyc));
            else begin
               case (pin_kind[pin_rd])
                  0: begin
                     chk("pin_pulse", 64'(mul_valid_out), 64'd1);
                     chk("pin_pulse_busy", 64'(mul_unit_busy), 64'd0);
                     chk("pin_result", 64'(mul_output), 64'(pin_val[pin_rd]));
                  end
                  1: begin
                     chk("pin_quiet_busy", 64'(mul_unit_busy), 64'd0);
                     chk("pin_quiet_valid", 64'(mul_valid_out), 64'd0);
                  end
                  2: begin
                     chk("pin_rst_busy", 64'(mul_unit_busy), 64'd0);
                     chk("pin_rst_valid", 64'(mul_valid_out), 64'd0);
                     chk("pin_rst_out", 64'(mul_output), 64'd0);
                  end
                  default: chk("pin_busy", 64'(mul_unit_busy), 64'd1);
               endcase
            end
            pin_rd++;
         end
         if (done) begin
            chk("pins_consumed", 64'(pin_rd), 64'(pin_wr));
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   // ---------------- driver ----------------
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) step();
   endtask

   task automatic add_pin(input int c, input int kind, input logic [31:0] v);
      pin_cyc[pin_wr]  = c;
      pin_kind[pin_wr] = kind;
      pin_val[pin_wr]  = v;
      pin_wr++;
   endtask

   task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [7:0] acc, input logic [6:0] f7);
      mul_valid_in   = 1'b1;
      opcode         = 7'b0110011;
      funct7         = f7;
      funct3         = f3;
      rs1            = a;
      rs2            = b;
      accuracy_level = acc;
   endtask

   task automatic lit_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [7:0] acc, input logic [31:0] val, input int lat);
      int c;
      c = cyc;
      drive(f3, a, b, acc, 7'b0000001);
      add_pin(c + 2, 3, 32'd0);
      add_pin(c + lat + 2, 0, val);
      step();
      mul_valid_in = 1'b0;
      wait_until(c + lat + 2);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin : driver
      int c;
      add_pin(1, 2, 32'd0);
      add_pin(2, 2, 32'd0);
      repeat (3) step();
      reset_n = 1'b1;
      step();

      lit_op(3'b000, 32'd10, 32'd20, 8'd0, 32'd200, 16);
      lit_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd0, 32'h0000_0000, 16);
      lit_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd0, 32'hFFFF_FFFE, 16);
      lit_op(3'b010, 32'hFFFF_FFFF, 32'd2, 8'd0, 32'hFFFF_FFFF, 16);
      lit_op(3'b000, 32'h8000_0000, 32'd2, 8'd0, 32'h0000_0000, 16);
      lit_op(3'b001, 32'h8000_0000, 32'h8000_0000, 8'd0, 32'h4000_0000, 16);
`ifdef APX_ACC_CONTROL_EN
      lit_op(3'b000, 32'd10, 32'd20, 8'd1, 32'd200, 16);
      lit_op(3'b000, 32'd10, 32'd20, 8'd2, 32'd160, 15);
      lit_op(3'b000, 32'd10, 32'd20, 8'd4, 32'd0, 14);
`else
      lit_op(3'b000, 32'd10, 32'd20, 8'd4, 32'd200, 16);
`endif

      // ignored requests: DIV encoding and non-M funct7
      c = cyc;
      drive(3'b100, 32'd10, 32'd20, 8'd0, 7'b0000001);
      add_pin(c + 2, 1, 32'd0);
      add_pin(c + 3, 1, 32'd0);
      step();
      mul_valid_in = 1'b0;
      wait_until(c + 3);
      c = cyc;
      drive(3'b000, 32'd10, 32'd20, 8'd0, 7'b0000000);
      add_pin(c + 2, 1, 32'd0);
      add_pin(c + 3, 1, 32'd0);
      step();
      mul_valid_in = 1'b0;
      wait_until(c + 3);

      // request held during CALC with other operands, dropped before DONE
      c = cyc;
      drive(3'b000, 32'd10, 32'd20, 8'd0, 7'b0000001);
      add_pin(c + 2, 3, 32'd0);
      add_pin(c + 18, 0, 32'd200);
      step();
      mul_valid_in = 1'b0;
      step();
      drive(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd0, 7'b0000001);
      repeat (10) step();
      mul_valid_in = 1'b0;
      wait_until(c + 18);

      // back-to-back: second request presented in the DONE cycle
      c = cyc;
      drive(3'b000, 32'd10, 32'd20, 8'd0, 7'b0000001);
      add_pin(c + 2, 3, 32'd0);
      add_pin(c + 18, 0, 32'd200);
      step();
      mul_valid_in = 1'b0;
      wait_until(c + 17);
      drive(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd0, 7'b0000001);
      add_pin(c + 19, 3, 32'd0);
      add_pin(c + 35, 0, 32'hFFFF_FFFE);
      step();
      mul_valid_in = 1'b0;
      wait_until(c + 35);

      // asynchronous reset in the middle of CALC
      c = cyc;
      drive(3'b000, 32'd10, 32'd20, 8'd0, 7'b0000001);
      add_pin(c + 2, 3, 32'd0);
      step();
      mul_valid_in = 1'b0;
      wait_until(c + 6);
      reset_n = 1'b0;
      add_pin(c + 7, 2, 32'd0);
      step();
      step();
      reset_n = 1'b1;
      add_pin(c + 18, 1, 32'd0);
      wait_until(c + 19);
      lit_op(3'b000, 32'd7, 32'd9, 8'd0, 32'd63, 16);

      // randomized traffic against the model
      repeat (2500) begin
         mul_valid_in   = ($urandom_range(0, 9) < 4);
         opcode         = ($urandom_range(0, 15) == 0) ? 7'b0010011 : 7'b0110011;
         funct7         = ($urandom_range(0, 15) == 0) ? 7'b0100000 : 7'b0000001;
         funct3         = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7))
                                                      : 3'($urandom_range(0, 3));
         rs1            = pick();
         rs2            = pick();
         accuracy_level = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(0, 40));
         if ($urandom_range(0, 30) == 0) accuracy_level = 8'd255;
         step();
      end
      mul_valid_in = 1'b0;
      repeat (40) step();
      done = 1'b1;
   end

endmodule

// File: doc/sequential_multiplier_unit.md
# sequential_multiplier_unit

Iterative, parametrised RV32M/RV64M multiplier for the phoeniX execute stage, successor to the single-shot multiplier unit. Handles MUL, MULH, MULHSU and MULHU by processing `BITS_PER_CYCLE` multiplier bits per clock under a valid/busy handshake. Optional operand-truncation approximation trades accuracy for latency via `accuracy_level`. Sits beside the ALU and divider and is stalled on by the pipeline through `mul_unit_busy`.

## Interface
- `XLEN`, 32: operand and result width; must be 32 or 64.
- `BITS_PER_CYCLE`, 2: multiplier bits consumed per iteration; must be 1, 2 or 4. `N = XLEN/BITS_PER_CYCLE`.
- `CLK` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `mul_valid_in` input 1: request strobe from the decode/execute stage.
- `opcode` input 7: instruction opcode.
- `funct7` input 7: instruction funct7.
- `funct3` input 3: instruction funct3.
- `accuracy_level` input 8: approximation level; 0 means exact.
- `rs1` input XLEN: multiplicand.
- `rs2` input XLEN: multiplier.
- `mul_unit_busy` output 1: iteration in progress.
- `mul_valid_out` output 1: one-cycle result-ready pulse.
- `mul_output` output XLEN: result, held until the next completion.

## Operation
- Request decode: `mul_valid_in` high, `opcode`=0110011, `funct7`=0000001 and `funct3[2]`=0. Any other request is ignored: no state change and no pulse.
- funct3 000 MUL returns the low XLEN bits. 001 MULH is signed×signed, high half. 010 MULHSU is signed rs1 × unsigned rs2, high half. 011 MULHU is unsigned×unsigned, high half.
- On accept, the block registers the operand magnitudes, the result sign (XOR of the operand signs, each counted only when that operand is signed per funct3), and the selected half. Accumulation is an unsigned 2·XLEN shift-add. At completion the product is two's-complement negated if the sign bit is set, then the half is selected.
- Approximation, with the macro enabled: `k = min(accuracy_level, XLEN/2)`. The low k bits of both magnitudes are forced to 0. The first `floor(k/BITS_PER_CYCLE)` multiplier digits are skipped, so iterations = `N − floor(k/BITS_PER_CYCLE)`. With k=0 the result is bit-exact.
- FSM states:
  - IDLE to CALC on accept; the iteration counter loads.
  - CALC: one digit per edge, counter decrements. Moves to DONE when the counter reaches 0; `mul_output` registers on that edge.
  - DONE: `mul_valid_out`=1. Goes to CALC if a new request is accepted in this cycle, otherwise to IDLE.
- Requests are accepted only in IDLE or DONE. Requests during CALC are dropped, with no queue; the requester must hold the request until `mul_unit_busy` is low.
- Operand inputs are sampled only at accept. Changes during CALC have no effect.

## Timing
- Reset, asynchronous and applied at any time including mid-CALC: state=IDLE, `mul_unit_busy`=0, `mul_valid_out`=0, `mul_output`=0, counter and accumulators cleared. No pulse is issued for an aborted operation.
- Accept edge E0. `mul_unit_busy` is high during the cycles between E0 and E_L, where L = iteration count; that is L cycles.
- `mul_valid_out` is high for exactly the one cycle after E_L. `mul_unit_busy` is low in that cycle.
- Exact latency is N cycles from accept to the valid cycle: 16 for XLEN=32 with BITS_PER_CYCLE=2.
- Back-to-back: a request accepted in the DONE cycle raises busy on the next cycle. Throughput is one result per L+1 cycles.

## Configuration
- `APX_ACC_CONTROL_EN` defined: the approximation path described above is built in.
- `APX_ACC_CONTROL_EN` undefined: `accuracy_level` is ignored, there is no truncation or skip logic, and every operation takes N iterations with an exact result.

## Test plan
- MUL, rs1=10, rs2=20, accuracy_level=0 (XLEN=32, BITS_PER_CYCLE=2) -> busy for 16 cycles, then one pulse with `mul_output`=200.
- MULH with 0xFFFFFFFF × 0xFFFFFFFF -> 0. MULHU with the same operands -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF. MUL 0x80000000 × 2 -> 0.
- Macro defined, MUL 10×20: accuracy_level=1 -> 200 in 16 cycles; =2 -> 160 in 15 cycles; =4 -> 0 in 14 cycles. Macro undefined with accuracy_level=4 -> 200 in 16 cycles.
- Request held during CALC with different operands -> ignored. funct3=100 (DIV) or funct7=0000000 -> no busy and no pulse.
- Request accepted in the DONE cycle -> first pulse carries result A, busy rises on the next cycle, second pulse 17 cycles after the first.
- `reset_n` low at CALC iteration 5 -> all outputs 0 immediately. No pulse after release. A fresh request after release completes normally.
